// File: rtl/wb_merge_unit_if.sv
// wb_merge_unit_if: producer request channels and register-file write port of wb_merge_unit.
//   srcValid/srcReady/srcAddr/srcData : NUM_SRC packed valid/ready request channels
//   wbEn/wbAddr/wbData                : registered register-file write port
//   drained                           : nothing queued and no write in flight
//   pendMask                          : per-register pending-write mask (only with WB_MERGE_PENDING_EN)
//   master = producer/register-file side, slave = merge unit
interface wb_merge_unit_if #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int NUM_SRC = 3
);
    logic [NUM_SRC-1:0]        srcValid;
    logic [NUM_SRC-1:0]        srcReady;
    logic [NUM_SRC*ADDR_W-1:0] srcAddr;
    logic [NUM_SRC*DATA_W-1:0] srcData;
    logic                      wbEn;
    logic [ADDR_W-1:0]         wbAddr;
    logic [DATA_W-1:0]         wbData;
    logic                      drained;
`ifdef WB_MERGE_PENDING_EN
    logic [2**ADDR_W-1:0]      pendMask;
`endif
    modport master (
        output srcValid, srcAddr, srcData,
        input  srcReady, wbEn, wbAddr, wbData, drained
`ifdef WB_MERGE_PENDING_EN
        , input pendMask
`endif
    );
    modport slave (
        input  srcValid, srcAddr, srcData,
        output srcReady, wbEn, wbAddr, wbData, drained
`ifdef WB_MERGE_PENDING_EN
        , output pendMask
`endif
    );
endinterface

// File: rtl/wb_merge_unit.sv
// wb_merge_unit: merges NUM_SRC writeback producers through per-channel FIFOs onto one registered register-file write port.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : wb_merge_unit_if.slave (srcValid/srcReady/srcAddr/srcData in, wbEn/wbAddr/wbData/drained out)
//   Optional macro WB_MERGE_PENDING_EN adds bus.pendMask, a per-register pending-write scoreboard.
module wb_merge_unit #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int NUM_SRC    = 3,
    parameter int FIFO_DEPTH = 4
) (
    input logic             clk,
    input logic             rst,
    wb_merge_unit_if.slave  bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(NUM_SRC);

    logic [ADDR_W-1:0]             addr_mem_q [NUM_SRC][FIFO_DEPTH];
    logic [ADDR_W-1:0]             addr_mem_d [NUM_SRC][FIFO_DEPTH];
    logic [DATA_W-1:0]             data_mem_q [NUM_SRC][FIFO_DEPTH];
    logic [DATA_W-1:0]             data_mem_d [NUM_SRC][FIFO_DEPTH];
    logic [NUM_SRC-1:0][PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [NUM_SRC-1:0][CW-1:0]    count_q, count_d;
    logic [SW-1:0]                 rr_ptr_q, rr_ptr_d;
    logic                          wb_en_q, wb_en_d;
    logic [ADDR_W-1:0]             wb_addr_q, wb_addr_d;
    logic [DATA_W-1:0]             wb_data_q, wb_data_d;
    logic [NUM_SRC-1:0]            ready, push, pop;
    logic                          grant_valid;
    logic [SW-1:0]                 grant;
    logic [ADDR_W-1:0]             head_addr;
    logic [DATA_W-1:0]             head_data;

    // Round-robin search: scanning offsets from high to low lets the lowest
    // non-empty offset from rr_ptr_q win.
    always_comb begin
        grant_valid = 1'b0;
        grant       = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (count_q[(int'(rr_ptr_q) + k) % NUM_SRC] != '0) begin
                grant_valid = 1'b1;
                grant       = SW'((int'(rr_ptr_q) + k) % NUM_SRC);
            end
        end
        head_addr = addr_mem_q[grant][rd_ptr_q[grant]];
        head_data = data_mem_q[grant][rd_ptr_q[grant]];
    end

    always_comb begin
        addr_mem_d = addr_mem_q;
        data_mem_d = data_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        ready      = '0;
        push       = '0;
        pop        = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            // Readiness is pure FIFO state, so a full FIFO refuses even while popping.
            ready[i] = count_q[i] != CW'(FIFO_DEPTH);
            push[i]  = bus.srcValid[i] && ready[i];
            pop[i]   = grant_valid && (grant == SW'(i));
            if (push[i]) begin
                addr_mem_d[i][wr_ptr_q[i]] = bus.srcAddr[i*ADDR_W +: ADDR_W];
                data_mem_d[i][wr_ptr_q[i]] = bus.srcData[i*DATA_W +: DATA_W];
            end
            wr_ptr_d[i] = wr_ptr_q[i] + PW'(push[i]);
            rd_ptr_d[i] = rd_ptr_q[i] + PW'(pop[i]);
            count_d[i]  = count_q[i] + CW'(push[i]) - CW'(pop[i]);
        end
        rr_ptr_d  = !grant_valid ? rr_ptr_q : (grant == SW'(NUM_SRC - 1)) ? '0 : grant + 1'b1;
        // Register-0 writes are consumed but never raise the write enable.
        wb_en_d   = grant_valid && (head_addr != '0);
        wb_addr_d = grant_valid ? head_addr : wb_addr_q;
        wb_data_d = grant_valid ? head_data : wb_data_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_mem_q <= '{default: '0};
            data_mem_q <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rr_ptr_q   <= '0;
            wb_en_q    <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
        end else begin
            addr_mem_q <= addr_mem_d;
            data_mem_q <= data_mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rr_ptr_q   <= rr_ptr_d;
            wb_en_q    <= wb_en_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
        end
    end

    assign bus.srcReady = ready;
    assign bus.wbEn     = wb_en_q;
    assign bus.wbAddr   = wb_addr_q;
    assign bus.wbData   = wb_data_q;
    assign bus.drained  = (count_q == '0) && !wb_en_q;

`ifdef WB_MERGE_PENDING_EN
    // One counter per register: worst case every FIFO slot plus the output register target it.
    localparam int PCW = $clog2(NUM_SRC * FIFO_DEPTH + 2);
    logic [2**ADDR_W-1:0][PCW-1:0] pend_cnt_q, pend_cnt_d;
    logic [2**ADDR_W-1:0]          pend_mask;

    // Register-0 entries are never counted, matching their suppressed write enable.
    always_comb begin
        pend_cnt_d = pend_cnt_q;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (push[i] && (bus.srcAddr[i*ADDR_W +: ADDR_W] != '0))
                pend_cnt_d[bus.srcAddr[i*ADDR_W +: ADDR_W]] = pend_cnt_d[bus.srcAddr[i*ADDR_W +: ADDR_W]] + 1'b1;
        end
        if (wb_en_q)
            pend_cnt_d[wb_addr_q] = pend_cnt_d[wb_addr_q] - 1'b1;
        pend_mask = '0;
        for (int r = 1; r < 2**ADDR_W; r++)
            pend_mask[r] = |pend_cnt_q[r];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pend_cnt_q <= '0;
        else     pend_cnt_q <= pend_cnt_d;
    end

    assign bus.pendMask = pend_mask;
`endif
endmodule

// File: tb/tb_wb_merge_unit.sv
// tb_wb_merge_unit: directed self-checking bench for wb_merge_unit (3 channels, depth 4).
module tb_wb_merge_unit;
    localparam int DATA_W = 32, ADDR_W = 5, NUM_SRC = 3, FIFO_DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    wb_merge_unit_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_SRC(NUM_SRC)) bus ();

    wb_merge_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_SRC(NUM_SRC), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int i, input logic v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bus.srcValid[i]                 = v;
        bus.srcAddr[i*ADDR_W +: ADDR_W] = a;
        bus.srcData[i*DATA_W +: DATA_W] = d;
    endtask

    task automatic pulse_reset();
        #2 rst = 1'b1;
        #2 rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent, got, cyc;
        logic acc, saw_full;
        rst          = 1'b1;
        bus.srcValid = '0;
        bus.srcAddr  = '0;
        bus.srcData  = '0;
        #3;
        check("rst_wben", bus.wbEn, 0);
        check("rst_wbaddr", bus.wbAddr, 0);
        check("rst_wbdata", bus.wbData, 0);
        check("rst_ready", bus.srcReady, 3'b111);
        check("rst_drained", bus.drained, 1);
        @(negedge clk);
        rst = 1'b0;

        // single request on ch1: visible one cycle after acceptance
        tick();
        set_ch(1, 1, 5'd5, 32'hDEADBEEF);
        tick();
        set_ch(1, 0, 0, 0);
        check("t1_accept_wben", bus.wbEn, 0);
        check("t1_accept_drained", bus.drained, 0);
        tick();
        check("t1_wben", bus.wbEn, 1);
        check("t1_wbaddr", bus.wbAddr, 5);
        check("t1_wbdata", bus.wbData, 32'hDEADBEEF);
        check("t1_busy_drained", bus.drained, 0);
        tick();
        check("t1_done_wben", bus.wbEn, 0);
        check("t1_done_drained", bus.drained, 1);

        // register-0 write: popped, loads data, never enables
        set_ch(0, 1, 5'd0, 32'h1234);
        tick();
        set_ch(0, 0, 0, 0);
        check("t2_accept_wben", bus.wbEn, 0);
        check("t2_accept_drained", bus.drained, 0);
        tick();
        check("t2_pop_wben", bus.wbEn, 0);
        check("t2_pop_wbdata", bus.wbData, 32'h1234);
        check("t2_pop_drained", bus.drained, 1);
        tick();
        check("t2_after_wben", bus.wbEn, 0);

        // full contention: grants rotate ch0, ch1, ch2
        pulse_reset();
        for (int i = 0; i < NUM_SRC; i++) set_ch(i, 1, ADDR_W'(i + 1), 32'hA000_0000 + i);
        tick();
        check("t3_first_wben", bus.wbEn, 0);
        for (int j = 0; j < 9; j++) begin
            tick();
            check($sformatf("t3_wben_%0d", j), bus.wbEn, 1);
            check($sformatf("t3_wbaddr_%0d", j), bus.wbAddr, (j % 3) + 1);
            check($sformatf("t3_wbdata_%0d", j), bus.wbData, 32'hA000_0000 + (j % 3));
        end
        bus.srcValid = '0;
        cyc = 0;
        while (!bus.drained && cyc < 40) begin
            tick();
            cyc++;
        end
        check("t3_drained", bus.drained, 1);

        // backpressure: ch2 sends 6 while ch0/ch1 saturate
        pulse_reset();
        set_ch(0, 1, 5'd10, 32'h0);
        set_ch(1, 1, 5'd11, 32'h1);
        set_ch(2, 1, 5'd20, 32'hC000_0000);
        sent = 0;
        got = 0;
        saw_full = 1'b0;
        cyc = 0;
        while (got < 6 && cyc < 80) begin
            acc = bus.srcValid[2] && bus.srcReady[2];
            tick();
            cyc++;
            if (acc) sent++;
            if (bus.wbEn && bus.wbAddr == 5'd20) begin
                check($sformatf("t4_order_%0d", got), bus.wbData, 32'hC000_0000 + got);
                got++;
            end
            if (!bus.srcReady[2]) saw_full = 1'b1;
            set_ch(2, sent < 6, 5'd20, 32'hC000_0000 + sent);
        end
        check("t4_saw_full", saw_full, 1);
        bus.srcValid = '0;
        cyc = 0;
        while (!bus.drained && cyc < 40) begin
            tick();
            cyc++;
            if (bus.wbEn && bus.wbAddr == 5'd20) got++;
        end
        check("t4_retired", got, 6);
        check("t4_drained", bus.drained, 1);

        // async reset with entries queued and a write in flight
        for (int i = 0; i < NUM_SRC; i++) set_ch(i, 1, ADDR_W'(i + 1), 32'hB000_0000 + i);
        tick();
        tick();
        bus.srcValid = '0;
        check("t5_pre_wben", bus.wbEn, 1);
        #2 rst = 1'b1;
        #1;
        check("t5_rst_wben", bus.wbEn, 0);
        check("t5_rst_ready", bus.srcReady, 3'b111);
        check("t5_rst_drained", bus.drained, 1);
        #1 rst = 1'b0;
        for (int j = 0; j < 5; j++) begin
            tick();
            check($sformatf("t5_post_wben_%0d", j), bus.wbEn, 0);
        end
        check("t5_post_drained", bus.drained, 1);

`ifdef WB_MERGE_PENDING_EN
        // pending scoreboard on register 7 from two channels
        set_ch(0, 1, 5'd7, 32'h70);
        set_ch(1, 1, 5'd7, 32'h71);
        tick();
        bus.srcValid = '0;
        check("t6_pend_push", bus.pendMask, 32'h80);
        tick();
        check("t6_pend_first", bus.pendMask, 32'h80);
        tick();
        check("t6_pend_second", bus.pendMask, 32'h80);
        tick();
        check("t6_pend_clear", bus.pendMask, 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
